// File: rtl/intt_scale_out.sv
// INTT output scaler: captures one D-coefficient vector, multiplies each
// coefficient by NINV mod Q through a shared 2-stage multiplier, and holds the result.
module intt_scale_out #(
  parameter int N    = 17,
  parameter int D    = 8,
  parameter int Q    = 257,
  parameter int NINV = 225
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D*N-1:0] a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D*N-1:0] b,
  output logic           busy
);

  localparam int             IW       = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(D - 1);
  localparam logic [2*N-1:0] NINV_W   = (2*N)'(NINV);
  localparam logic [2*N-1:0] Q_W      = (2*N)'(Q);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e         state_q;
  logic [D*N-1:0] cap_q;
  logic [IW-1:0]  idx_q;
  logic           issue_q;
  logic           s1_vld_q;
  logic           s1_last_q;
  logic [IW-1:0]  s1_idx_q;
  logic [2*N-1:0] prod_q;
  logic           s2_last_q;
  logic [D*N-1:0] b_q;

  logic [N-1:0]   coeff_d;
  logic [2*N-1:0] prod_d;
  logic [N-1:0]   red_d;

  assign coeff_d = cap_q[idx_q*N +: N];
  assign prod_d  = {{N{1'b0}}, coeff_d} * NINV_W;
  // Full-width remainder: exact for every N-bit input, including values >= Q.
  assign red_d   = N'(prod_q % Q_W);

  // NOTE: the capture register has no reset; it is only read in RUN, after
  // being loaded on the accepting edge, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      cap_q <= a;
    end
  end

  // NOTE: every state register uses non-blocking assignment so all flops
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      issue_q   <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_idx_q  <= '0;
      prod_q    <= '0;
      s2_last_q <= 1'b0;
      b_q       <= '0;
    end else begin
      s1_vld_q  <= (state_q == RUN) && issue_q;
      s1_last_q <= (state_q == RUN) && issue_q && (idx_q == LAST_IDX);
      s1_idx_q  <= idx_q;
      prod_q    <= prod_d;
      s2_last_q <= s1_vld_q && s1_last_q;

      if (s1_vld_q) begin
        b_q[s1_idx_q*N +: N] <= red_d;
      end

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            idx_q   <= '0;
            issue_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Index saturates at D-1 so a vector is never issued twice.
          if (issue_q) begin
            if (idx_q == LAST_IDX) begin
              issue_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
          if (s2_last_q) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign b         = b_q;

endmodule

// File: tb/tb_intt_scale_out.sv
// Directed bench for intt_scale_out: vector table plus reset, backpressure,
// back-to-back and abort sequences, all against hand-computed results.
module tb_intt_scale_out;

  localparam int N = 17;
  localparam int D = 8;
  localparam int W = D * N;
  localparam int LAT = D + 2;
  localparam int TMO = 50;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] b;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  intt_scale_out #(.N(N), .D(D), .Q(257), .NINV(225)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int v[D]);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < D; i++) p[i*N +: N] = N'(v[i]);
    return p;
  endfunction

  function automatic logic [W-1:0] garbage();
    return W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for exactly one accepting edge; returns after that edge.
  task automatic send(input string nm, input logic [W-1:0] v);
    int n;
    n = 0;
    while (!in_ready && n < TMO) begin
      tick();
      n++;
    end
    if (!in_ready) check({nm, " in_ready timeout"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    a        = v;
    tick();
    in_valid = 1'b0;
    a        = garbage();
  endtask

  // Count edges from the current point until out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < TMO);
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, " out_valid after hs"}, W'(out_valid), W'(0));
    check({nm, " in_ready after hs"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int av[D];
    int bv[D];
    int lat;
    logic [W-1:0] hold_b;
    logic ok;

    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    bv = '{225, 193, 161, 129, 97, 65, 33, 1};
    tbl[0] = '{"basic", pack(av), pack(bv)};
    av = '{0, 256, 257, 131071, 1, 1, 1, 1};
    bv = '{0, 32, 0, 225, 225, 225, 225, 225};
    tbl[1] = '{"boundary", pack(av), pack(bv)};
    av = '{2, 4, 6, 8, 10, 12, 14, 16};
    bv = '{193, 129, 65, 1, 194, 130, 66, 2};
    tbl[2] = '{"double", pack(av), pack(bv)};
    av = '{8, 8, 8, 8, 8, 8, 8, 8};
    bv = '{1, 1, 1, 1, 1, 1, 1, 1};
    tbl[3] = '{"eights", pack(av), pack(bv)};
    av = '{65536, 0, 65536, 0, 131071, 0, 257, 256};
    bv = '{225, 0, 225, 0, 225, 0, 0, 32};
    tbl[4] = '{"wide", pack(av), pack(bv)};
    av = '{0, 0, 0, 0, 0, 0, 0, 0};
    bv = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{"zeros", pack(av), pack(bv)};

    // Reset held while garbage is offered.
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = garbage();
    repeat (3) tick();
    check("rst in_ready", W'(in_ready), W'(1));
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst busy", W'(busy), W'(0));
    check("rst b", b, '0);
    rst = 1'b1;
    #1;
    check("rst release no capture", W'(busy), W'(0));
    in_valid = 1'b0;
    tick();
    check("post rst idle", W'(busy), W'(0));

    // Table-driven vectors.
    for (int t = 0; t < 6; t++) begin
      send(tbl[t].name, tbl[t].a);
      check({tbl[t].name, " busy"}, W'(busy), W'(1));
      check({tbl[t].name, " in_ready low"}, W'(in_ready), W'(0));
      wait_out(lat);
      check({tbl[t].name, " latency"}, W'(lat), W'(LAT));
      check({tbl[t].name, " b"}, b, tbl[t].b);
      handshake(tbl[t].name);
      check({tbl[t].name, " b held in idle"}, b, tbl[t].b);
    end

    // Backpressure: result and flags hold, a new offer is ignored.
    send("bp", tbl[0].a);
    wait_out(lat);
    check("bp latency", W'(lat), W'(LAT));
    hold_b = b;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        in_valid = 1'b1;
        a        = tbl[3].a;
      end
      tick();
      in_valid = 1'b0;
      if (!out_valid || in_ready || busy || b !== hold_b) ok = 1'b0;
    end
    check("bp hold", W'(ok), W'(1));
    check("bp b", b, tbl[0].b);
    handshake("bp");
    tick();
    check("bp no stale capture", W'(busy), W'(0));

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = tbl[1].a;
    tick();
    a = tbl[2].a;
    wait_out(lat);
    check("b2b first latency", W'(lat), W'(LAT));
    check("b2b first b", b, tbl[1].b);
    wait_out(lat);
    in_valid = 1'b0;
    check("b2b gap", W'(lat), W'(12));
    check("b2b second b", b, tbl[2].b);
    tick();
    out_ready = 1'b0;
    check("b2b final idle", W'(in_ready), W'(1));

    // Abort at idx 4, then a clean vector must show no stale coefficients.
    send("abort", tbl[4].a);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("abort busy", W'(busy), W'(0));
    check("abort out_valid", W'(out_valid), W'(0));
    check("abort in_ready", W'(in_ready), W'(1));
    check("abort b cleared", b, '0);
    tick();
    rst = 1'b1;
    tick();
    send("after abort", tbl[3].a);
    wait_out(lat);
    check("after abort latency", W'(lat), W'(LAT));
    check("after abort b", b, tbl[3].b);
    handshake("after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
